// File: rtl/data_mem_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_mem_pkg : shared types and build checks for data_mem_ctrl | rev 1.0
// -----------------------------------------------------------------------------
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DATA_W_NARROW = 32;
    localparam int DATA_W_WIDE   = 64;
    localparam int RD_LAT_MIN    = 1;
    localparam int RD_LAT_MAX    = 4;
    localparam int CNT_W         = 2;

    function automatic logic cfg_legal(input int data_w, input int depth, input int rd_lat);
        logic w_ok;
        logic d_ok;
        logic l_ok;
        w_ok = (data_w == DATA_W_NARROW) || (data_w == DATA_W_WIDE);
        d_ok = (depth > 0) && ((depth & (depth - 1)) == 0) && ((depth % (data_w / 8)) == 0);
        l_ok = (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
        return w_ok && d_ok && l_ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_lane_align : store strobe/shift and load extract/extend | rev 1.0
// -----------------------------------------------------------------------------
module mem_lane_align
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  size_e                       st_size_i,
    input  logic [$clog2(DATA_W/8)-1:0] st_lane_i,
    input  logic [DATA_W-1:0]           st_wdata_i,
    output logic [DATA_W/8-1:0]         st_strb_o,
    output logic [DATA_W-1:0]           st_data_o,
    input  size_e                       ld_size_i,
    input  logic [$clog2(DATA_W/8)-1:0] ld_lane_i,
    input  logic                        ld_unsigned_i,
    input  logic [DATA_W-1:0]           ld_word_i,
    output logic [DATA_W-1:0]           ld_data_o
);

    localparam int NB    = DATA_W / 8;
    localparam int BIT_W = $clog2(DATA_W);

    always_comb begin : p_store
        int nbytes;
        nbytes = 1 << st_size_i;
        for (int b = 0; b < NB; b++) begin
            st_strb_o[b] = (b >= int'(st_lane_i)) && (b < int'(st_lane_i) + nbytes);
        end
        st_data_o = st_wdata_i << {st_lane_i, 3'b000};
    end

    always_comb begin : p_load
        logic [DATA_W-1:0] shifted;
        logic [BIT_W-1:0]  sidx;
        logic              sign;
        int                nbits;
        shifted = ld_word_i >> {ld_lane_i, 3'b000};
        nbits   = 8 << ld_size_i;
        // Oversized requests fault upstream; clamp only keeps the sign index in range.
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        sidx = BIT_W'(nbits - 1);
        sign = ~ld_unsigned_i & shifted[sidx];
        for (int i = 0; i < DATA_W; i++) begin
            ld_data_o[i] = (i < nbits) ? shifted[i] : sign;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_mem_ctrl : byte-addressable data RAM, single-outstanding req/resp | rev 1.0
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 64,
    parameter int                DEPTH_BYTES = 2048,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(64'h8000_0000),
    parameter int                RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int WORDS  = DEPTH_BYTES / NB;
    localparam int IDX_W  = $clog2(WORDS);
    localparam logic CFG_OK = cfg_legal(DATA_W, DEPTH_BYTES, RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    // An illegal build faults every access rather than corrupting memory.
    function automatic logic f_fault(input logic [ADDR_W-1:0] addr, input size_e sz);
        logic [3:0]        nbytes;
        logic [ADDR_W-1:0] offs;
        logic              misal;
        logic              too_big;
        logic              oor;
        nbytes  = 4'(32'd1 << sz);
        misal   = |(addr[2:0] & 3'(nbytes - 4'd1));
        too_big = nbytes > 4'(NB);
        offs    = addr - BASE_ADDR;
        oor     = offs >= ADDR_W'(DEPTH_BYTES);
        return misal | too_big | oor | ~CFG_OK;
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    size_e               size_q;
    logic                uns_q;
    logic [DATA_W-1:0]   rword_q;
    logic [DATA_W-1:0]   ram_q [WORDS];

    logic                w_accept;
    logic                w_in_fault;
    logic                w_fault;
    logic [ADDR_W-1:0]   w_in_offs;
    logic [IDX_W-1:0]    w_in_idx;
    logic [NB-1:0]       w_st_strb;
    logic [DATA_W-1:0]   w_st_data;
    logic [DATA_W-1:0]   w_ld_data;

    assign w_accept   = req_valid & (state_q == ST_IDLE);
    assign w_in_fault = f_fault(req_addr, size_e'(req_size));
    assign w_fault    = f_fault(addr_q, size_q);
    assign w_in_offs  = req_addr - BASE_ADDR;
    assign w_in_idx   = w_in_offs[LANE_W +: IDX_W];

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_size_i     (size_e'(req_size)),
        .st_lane_i     (req_addr[LANE_W-1:0]),
        .st_wdata_i    (req_wdata),
        .st_strb_o     (w_st_strb),
        .st_data_o     (w_st_data),
        .ld_size_i     (size_q),
        .ld_lane_i     (addr_q[LANE_W-1:0]),
        .ld_unsigned_i (uns_q),
        .ld_word_i     (rword_q),
        .ld_data_o     (w_ld_data)
    );

    // RAM holds no reset; a store commits on its acceptance edge.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            rword_q <= ram_q[w_in_idx];
            if (req_we && !w_in_fault) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_st_strb[b]) begin
                        ram_q[w_in_idx][8*b +: 8] <= w_st_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            if (w_accept) begin
                we_q   <= req_we;
                addr_q <= req_addr;
                size_q <= size_e'(req_size);
                uns_q  <= req_unsigned;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    cnt_d   = '0;
                    state_d = (req_we || RD_LAT <= 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // First RESP cycle launches the response; it then holds until taken.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    err_d        = w_fault;
                    rdata_d      = (w_fault || we_q) ? '0 : w_ld_data;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    err_d        = 1'b0;
                    rdata_d      = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = resp_valid_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl : directed checks on 64b/lat1, 64b/lat3 and 32b/lat1 builds | rev 1.0
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid_v;
    logic [2:0]  resp_ready_v;
    logic        req_we;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic        err0, err1, err2;
    logic [63:0] rdata0, rdata1;
    logic [31:0] rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(64), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_v[0]), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(vld0), .resp_ready(resp_ready_v[0]), .resp_rdata(rdata0), .resp_err(err0)
    );

    data_mem_ctrl #(.DATA_W(64), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid_v[1]), .req_ready(rdy1),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(vld1), .resp_ready(resp_ready_v[1]), .resp_rdata(rdata1), .resp_err(err1)
    );

    data_mem_ctrl #(.DATA_W(32), .RD_LAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid_v[2]), .req_ready(rdy2),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata[31:0]),
        .resp_valid(vld2), .resp_ready(resp_ready_v[2]), .resp_rdata(rdata2), .resp_err(err2)
    );

    function automatic logic rdy_of(input int d);
        return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
    endfunction

    function automatic logic vld_of(input int d);
        return (d == 0) ? vld0 : (d == 1) ? vld1 : vld2;
    endfunction

    function automatic logic err_of(input int d);
        return (d == 0) ? err0 : (d == 1) ? err1 : err2;
    endfunction

    function automatic logic [63:0] rd_of(input int d);
        return (d == 0) ? rdata0 : (d == 1) ? rdata1 : {32'h0, rdata2};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input int d, input logic we, input logic [63:0] addr,
                         input logic [1:0] size, input logic uns, input logic [63:0] wdata);
        @(negedge clk);
        chk("ready_before_req", {63'h0, rdy_of(d)}, 64'h1);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid_v[d] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v  = '0;
        req_addr     = '1;
        req_wdata    = '1;
        req_size     = 2'd0;
        req_unsigned = ~uns;
    endtask

    task automatic wait_resp(input int d, output int lat);
        lat = 0;
        while (!vld_of(d) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input int d);
        @(negedge clk);
        resp_ready_v[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_v[d] = 1'b0;
    endtask

    task automatic tx(input string tag, input int d, input logic we, input logic [63:0] addr,
                      input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                      input logic [63:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        issue(d, we, addr, size, uns, wdata);
        wait_resp(d, lat);
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".rdata"}, rd_of(d), exp_rd);
        chk({tag, ".err"}, {63'h0, err_of(d)}, {63'h0, exp_err});
        consume(d);
    endtask

    initial begin
        int lat;
        rst          = 1'b0;
        req_valid_v  = '0;
        resp_ready_v = '0;
        req_we       = 1'b0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", {63'h0, rdy0}, 64'h1);
        chk("rst.valid", {63'h0, vld0}, 64'h0);
        chk("rst.rdata", rdata0, 64'h0);
        chk("rst.err",   {63'h0, err0}, 64'h0);
        chk("rst.valid3", {63'h0, vld1}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // 64-bit, latency 1
        tx("st_d",      0, 1'b1, BASE,          2'd3, 1'b0, 64'h1122334455667788, 64'h0, 1'b0, 1);
        tx("ld_d",      0, 1'b0, BASE,          2'd3, 1'b0, 64'h0, 64'h1122334455667788, 1'b0, 1);
        tx("st_b",      0, 1'b1, BASE + 3,      2'd0, 1'b0, 64'hDEAD_0080, 64'h0, 1'b0, 1);
        tx("ld_b_s",    0, 1'b0, BASE + 3,      2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 1);
        tx("ld_b_u",    0, 1'b0, BASE + 3,      2'd0, 1'b1, 64'h0, 64'h80, 1'b0, 1);
        tx("ld_w_u",    0, 1'b0, BASE,          2'd2, 1'b1, 64'h0, 64'h80667788, 1'b0, 1);
        tx("ld_w_s",    0, 1'b0, BASE,          2'd2, 1'b0, 64'h0, 64'hFFFFFFFF80667788, 1'b0, 1);
        tx("ld_w_mis",  0, 1'b0, BASE + 2,      2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 1);
        tx("st_h_oor",  0, 1'b1, BASE + 'h801,  2'd1, 1'b0, 64'hBEEF, 64'h0, 1'b1, 1);
        tx("st_h_oor2", 0, 1'b1, BASE + 'h800,  2'd1, 1'b0, 64'hBEEF, 64'h0, 1'b1, 1);
        tx("ld_below",  0, 1'b0, 64'h7FFFFFFC,  2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 1);
        tx("ld_d_keep", 0, 1'b0, BASE,          2'd3, 1'b0, 64'h0, 64'h1122334480667788, 1'b0, 1);
        tx("st_h_top",  0, 1'b1, BASE + 6,      2'd1, 1'b0, 64'h1234_A5B6, 64'h0, 1'b0, 1);
        tx("ld_d_h",    0, 1'b0, BASE,          2'd3, 1'b0, 64'h0, 64'hA5B6334480667788, 1'b0, 1);
        tx("ld_h_s",    0, 1'b0, BASE + 6,      2'd1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFA5B6, 1'b0, 1);
        tx("st_b_last", 0, 1'b1, BASE + 'h7FF,  2'd0, 1'b0, 64'h5A, 64'h0, 1'b0, 1);
        tx("ld_b_last", 0, 1'b0, BASE + 'h7FF,  2'd0, 1'b1, 64'h0, 64'h5A, 1'b0, 1);

        // 64-bit, latency 3
        tx("l3_st_w",   1, 1'b1, BASE + 16,     2'd2, 1'b0, 64'hCAFEF00D, 64'h0, 1'b0, 1);
        tx("l3_ld_w",   1, 1'b0, BASE + 16,     2'd2, 1'b1, 64'h0, 64'hCAFEF00D, 1'b0, 3);
        tx("l3_ld_mis", 1, 1'b0, BASE + 17,     2'd1, 1'b0, 64'h0, 64'h0, 1'b1, 3);

        issue(1, 1'b0, BASE + 16, 2'd2, 1'b0, 64'h0);
        wait_resp(1, lat);
        chk("stall.lat", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall.valid", {63'h0, vld1}, 64'h1);
            chk("stall.rdata", rdata1, 64'hFFFFFFFFCAFEF00D);
            chk("stall.err",   {63'h0, err1}, 64'h0);
            chk("stall.ready", {63'h0, rdy1}, 64'h0);
        end
        consume(1);
        chk("taken.valid", {63'h0, vld1}, 64'h0);
        chk("taken.rdata", rdata1, 64'h0);
        chk("taken.ready", {63'h0, rdy1}, 64'h1);

        // 32-bit, latency 1
        tx("w32_d",     2, 1'b0, BASE,          2'd3, 1'b0, 64'h0, 64'h0, 1'b1, 1);
        tx("w32_st",    2, 1'b1, BASE + 4,      2'd2, 1'b0, 64'h89ABCDEF, 64'h0, 1'b0, 1);
        tx("w32_ld_hu", 2, 1'b0, BASE + 6,      2'd1, 1'b1, 64'h0, 64'h89AB, 1'b0, 1);
        tx("w32_ld_hs", 2, 1'b0, BASE + 6,      2'd1, 1'b0, 64'h0, 64'hFFFF89AB, 1'b0, 1);
        tx("w32_below", 2, 1'b0, 64'h7FFFFFFC,  2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 1);

        // Asynchronous reset while a load waits
        issue(1, 1'b0, BASE + 16, 2'd2, 1'b1, 64'h0);
        chk("wait.ready", {63'h0, rdy1}, 64'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.ready", {63'h0, rdy1}, 64'h1);
        chk("arst.valid", {63'h0, vld1}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst.dropped", {63'h0, vld1}, 64'h0);
        tx("arst_ld",   1, 1'b0, BASE + 16,     2'd2, 1'b1, 64'h0, 64'hCAFEF00D, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the core's data memory.
- Internal byte-addressable RAM behind a single-outstanding valid/ready request/response interface.
- Supports sized loads/stores (byte/half/word/dword) with sign/zero extension, a configurable read latency, and error reporting for misaligned, oversized or out-of-range accesses.
- Sits between the MEM stage and the memory array; replaces the fixed-width, fixed-timing access path.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, data/word width in bits; 32 or 64 only.
- DEPTH_BYTES, 2048, RAM size in bytes; must be a power of two and a multiple of DATA_W/8.
- BASE_ADDR, 64'h8000_0000, byte address mapped to RAM offset 0.
- RD_LAT, 1, read latency in cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts the request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_W  store data, low-aligned (LSB = byte at req_addr).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE, latency counter = 0.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- Acceptance: req_valid & req_ready at posedge N.
  - Request fields are registered at N. Inputs are don't-care afterwards.
- Error check (combinational on the registered request): err when any of
  - addr not aligned to 2^size;
  - 2^size > DATA_W/8 (dword on a 32-bit build);
  - (addr - BASE_ADDR) >= DEPTH_BYTES, computed as unsigned ADDR_W, so addresses below BASE wrap and fault.
- Store:
  - If no error, the RAM word at offset>>log2(DATA_W/8) is written at edge N with a byte strobe covering 2^size lanes starting at lane addr[log2(DATA_W/8)-1:0]. Data is shifted into lane position.
  - Erroneous stores do not modify RAM.
  - Transitions IDLE→RESP; resp_valid rises after edge N+1.
- Load:
  - IDLE→WAIT when RD_LAT > 1, otherwise IDLE→RESP.
  - The counter increments each cycle in WAIT; exit to RESP when the count reaches RD_LAT-1.
  - resp_valid rises after edge N+RD_LAT.
  - RAM is read at acceptance. Lane extraction: shift right by lane*8, mask to 2^size bytes, extend per req_unsigned to DATA_W.
  - A load never observes a later store, since only one request is outstanding.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready.
  - Then resp_valid goes to 0 and the state returns to IDLE. This costs one bubble cycle before the next acceptance.
  - resp_rdata is cleared to 0 when the response is consumed.
- Errors: resp_err = 1, resp_rdata = 0, same latency as the non-error path.
- Reset asserted mid-WAIT or mid-RESP: the in-flight response is dropped. A store already committed at acceptance stays written.
- resp_ready held high while idle has no effect.

Decomposition:
- Package data_mem_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - FSM state enum;
  - DATA_W legality check constants.
- Sub-module mem_lane_align (combinational):
  - store path: byte strobe and lane-shifted write data from size/offset/wdata;
  - load path: extraction plus sign/zero extension from the RAM word, offset, size and unsigned flag.
- RAM array and FSM stay in data_mem_ctrl.

Test Plan:
- DATA_W=64, RD_LAT=1: store dword 0x1122334455667788 at 0x80000000, then load dword → resp_rdata = 0x1122334455667788, err = 0. The load response comes 1 cycle after acceptance.
- Store byte 0x80 at 0x80000003, then load byte signed → 0xFFFFFFFFFFFFFF80; load byte unsigned → 0x80. Neighbouring bytes are unchanged (load word at 0x80000000 = 0x80667788 pattern check).
- Load word at 0x80000002 → err = 1, rdata = 0. Store half at 0x80000801 (out of range) → err = 1, and RAM is unchanged (verified by readback).
- RD_LAT=3: load accepted at edge N → resp_valid first seen high after N+3. Hold resp_ready low for 5 cycles → resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0.
- DATA_W=32: dword request → err = 1. Address 0x7FFFFFFC (below BASE) → err = 1.
- Assert rst low mid-WAIT → resp_valid = 0 and req_ready = 1 immediately (asynchronous). After release, a new load returns the correct data.
